load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameters: none; all widths fixed by the 32-bit ISA.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req_read  input  1  CPU load request; held until stall=0.
REQ-005 req_write  input  1  CPU store request; held until stall=0.
REQ-006 opcode  input  6  load/store opcode, from the shared package.
REQ-007 addr  input  32  effective byte address from the ALU.
REQ-008 store_data  input  32  rt value, CPU byte order.
REQ-009 stall  output  1  freezes the CPU pipeline while an access is in progress.
REQ-010 addr_err  output  1  one-cycle pulse on a misaligned request.
REQ-011 readdata_eb  output  32  registered, byte-swapped load word for the extract stage.
REQ-012 lsb_bits  output  2  registered addr[1:0] of the last completed load.
REQ-013 opcode_q  output  6  registered opcode of the last completed load.
REQ-014 address, read, write, byteenable, writedata  output  32/1/1/4/32  Avalon master request.
REQ-015 waitrequest, readdata  input  1/32  Avalon slave response.

Function
REQ-016 States SHALL be IDLE, RD_WAIT, WR_WAIT, DONE.
REQ-017 IDLE with req_read, aligned: register address={addr[31:2],2'b00}, read=1, byteenable=4'b1111; go to RD_WAIT.
REQ-018 IDLE with req_write, aligned: register address, write=1, byteenable and writedata per REQ-022/023; go to WR_WAIT.
REQ-019 RD_WAIT/WR_WAIT: hold address, byteenable, writedata, read, write stable while waitrequest=1, with no timeout.
REQ-020 RD_WAIT with waitrequest=0: capture readdata_eb, lsb_bits, opcode_q; deassert read; go to DONE.
REQ-021 WR_WAIT with waitrequest=0: deassert write; go to DONE.
REQ-022 Byte swap: readdata_eb = {readdata[7:0], readdata[15:8], readdata[23:16], readdata[31:24]}; store data SHALL use the same swap.
REQ-023 Store lanes, using CPU byte k mapped to bus byte 3-k:
  - SW: byteenable=1111.
  - SH at addr[1]=0: byteenable=1100. SH at addr[1]=1: byteenable=0011.
  - SB: byteenable one-hot at bit 3-addr[1:0].
  - writedata: the low byte or halfword of store_data, replicated across lanes before the swap.
REQ-024 stall = 1 in IDLE with a legal request, and in RD_WAIT and WR_WAIT; stall = 0 in DONE and otherwise.
REQ-025 Minimum access: 2 stalled cycles plus the DONE cycle.
REQ-026 DONE SHALL always return to IDLE after one cycle and SHALL ignore requests present in that cycle.
REQ-027 Misalignment:
  - LW/SW with addr[1:0]≠0, or LH/LHU/SH with addr[0]=1: pulse addr_err for one cycle.
  - No bus cycle is issued, stall=0, and captured registers are unchanged.
REQ-028 req_read and req_write both high: treated as a read; the write is ignored.
REQ-029 readdata_eb, lsb_bits, opcode_q SHALL hold their values until the next completed read.

Reset
REQ-030 Reset SHALL clear state to IDLE and all outputs and registers to 0, immediately and independent of clk.
REQ-031 Reset mid-access SHALL drop read/write without waiting for waitrequest; the access is abandoned.

Structure
REQ-032 The shared package SHALL hold OPCODE_LB/LBU/LH/LHU/LW/SB/SH/SW and the lsu_state_t enum.
REQ-033 The byte swap SHALL be one combinational sub-module, byte_swap, instantiated for the read path and the write path.

Verification
REQ-034 LW addr=0x100, waitrequest low 1 cycle, readdata=0x11223344 -> address=0x100, byteenable=1111, readdata_eb=0x44332211, stall high 2 cycles.
REQ-035 SB addr=0x203, store_data=0xAB, waitrequest high 3 cycles -> address=0x200 and byteenable=0001 stable throughout, writedata=0xABABABAB, stall high 5 cycles.
REQ-036 SH addr=0x302, store_data=0xBEEF -> byteenable=0011, writedata=0xEFBEEFBE.
REQ-037 LH addr=0x101 -> addr_err pulses once, read never asserted, stall=0, readdata_eb unchanged.
REQ-038 reset asserted in RD_WAIT with waitrequest=1 -> read=0 and state IDLE before the next edge; a new LW then completes normally.
REQ-039 Back-to-back LB addr=0x2 then LBU addr=0x3 -> each completes, and lsb_bits/opcode_q update to 2/LB then 3/LBU.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: MIPS-style load/store opcodes,
// the access state encoding and the store-lane helper functions.
package load_store_unit_pkg;

    localparam logic [5:0] OPCODE_LB  = 6'h20;
    localparam logic [5:0] OPCODE_LH  = 6'h21;
    localparam logic [5:0] OPCODE_LW  = 6'h23;
    localparam logic [5:0] OPCODE_LBU = 6'h24;
    localparam logic [5:0] OPCODE_LHU = 6'h25;
    localparam logic [5:0] OPCODE_SB  = 6'h28;
    localparam logic [5:0] OPCODE_SH  = 6'h29;
    localparam logic [5:0] OPCODE_SW  = 6'h2B;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2,
        DONE    = 2'd3
    } lsu_state_t;

    // Byte accesses can never be misaligned; unknown opcodes are treated like bytes.
    function automatic logic is_misaligned(input logic [5:0] op, input logic [1:0] lsb);
        logic bad;
        bad = 1'b0;
        case (op)
            OPCODE_LW, OPCODE_SW:             bad = (lsb != 2'b00);
            OPCODE_LH, OPCODE_LHU, OPCODE_SH: bad = lsb[0];
            default:                          bad = 1'b0;
        endcase
        return bad;
    endfunction

    // CPU byte k lands on bus byte 3-k, so lane selection counts down from bit 3.
    function automatic logic [3:0] store_lanes(input logic [5:0] op, input logic [1:0] lsb);
        logic [3:0] lanes;
        lanes = 4'b1111;
        case (op)
            OPCODE_SB: lanes = 4'b1000 >> lsb;
            OPCODE_SH: lanes = lsb[1] ? 4'b0011 : 4'b1100;
            default:   lanes = 4'b1111;
        endcase
        return lanes;
    endfunction

    function automatic logic [31:0] store_replicate(input logic [5:0] op, input logic [31:0] data);
        logic [31:0] rep;
        rep = data;
        case (op)
            OPCODE_SB: rep = {4{data[7:0]}};
            OPCODE_SH: rep = {2{data[15:0]}};
            default:   rep = data;
        endcase
        return rep;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Avalon-MM memory bus between the load/store unit (master) and memory (slave).
interface load_store_unit_if;

    logic [31:0] address;
    logic        read;
    logic        write;
    logic [3:0]  byteenable;
    logic [31:0] writedata;
    logic        waitrequest;
    logic [31:0] readdata;

    modport master (
        output address, read, write, byteenable, writedata,
        input  waitrequest, readdata
    );

    modport slave (
        input  address, read, write, byteenable, writedata,
        output waitrequest, readdata
    );

endinterface

// File: rtl/load_store_unit_byte_swap.sv
// Reverses the byte order of a 32-bit word; used on both the load and store paths.
module byte_swap (
    input  logic [31:0] data_in,
    output logic [31:0] data_out
);

    assign data_out = {data_in[7:0], data_in[15:8], data_in[23:16], data_in[31:24]};

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns CPU load/store requests into single Avalon-MM accesses,
// stalling the pipeline until the bus completes and flagging misaligned requests.
module load_store_unit
    import load_store_unit_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              req_read,
    input  logic              req_write,
    input  logic [5:0]        opcode,
    input  logic [31:0]       addr,
    input  logic [31:0]       store_data,
    output logic              stall,
    output logic              addr_err,
    output logic [31:0]       readdata_eb,
    output logic [1:0]        lsb_bits,
    output logic [5:0]        opcode_q,
    load_store_unit_if.master bus
);

    lsu_state_t  state;
    lsu_state_t  next_state;
    logic        misaligned;
    logic        any_req;
    logic        start_read;
    logic        start_write;
    logic [31:0] store_replicated;
    logic [31:0] store_swapped;
    logic [31:0] load_swapped;

    logic [31:0] address_r;
    logic        read_r;
    logic        write_r;
    logic [3:0]  byteenable_r;
    logic [31:0] writedata_r;
    logic [1:0]  pend_lsb;
    logic [5:0]  pend_opcode;

    byte_swap u_load_swap (
        .data_in  (bus.readdata),
        .data_out (load_swapped)
    );

    byte_swap u_store_swap (
        .data_in  (store_replicated),
        .data_out (store_swapped)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Read wins when both requests are present; DONE never accepts a new request.
    always_comb begin
        next_state       = state;
        start_read       = 1'b0;
        start_write      = 1'b0;
        stall            = 1'b0;
        addr_err         = 1'b0;
        misaligned       = is_misaligned(opcode, addr[1:0]);
        any_req          = req_read | req_write;
        store_replicated = store_replicate(opcode, store_data);
        case (state)
            IDLE: begin
                if (any_req) begin
                    if (misaligned) begin
                        addr_err = 1'b1;
                    end else if (req_read) begin
                        start_read = 1'b1;
                        stall      = 1'b1;
                        next_state = RD_WAIT;
                    end else begin
                        start_write = 1'b1;
                        stall       = 1'b1;
                        next_state  = WR_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                stall = 1'b1;
                if (!bus.waitrequest) begin
                    next_state = DONE;
                end
            end
            WR_WAIT: begin
                stall = 1'b1;
                if (!bus.waitrequest) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Bus request fields are loaded once at the start and then held untouched
    // until the slave releases waitrequest.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            address_r    <= '0;
            read_r       <= 1'b0;
            write_r      <= 1'b0;
            byteenable_r <= '0;
            writedata_r  <= '0;
            pend_lsb     <= '0;
            pend_opcode  <= '0;
            readdata_eb  <= '0;
            lsb_bits     <= '0;
            opcode_q     <= '0;
        end else begin
            if (start_read) begin
                address_r    <= {addr[31:2], 2'b00};
                read_r       <= 1'b1;
                byteenable_r <= 4'b1111;
                pend_lsb     <= addr[1:0];
                pend_opcode  <= opcode;
            end else if (start_write) begin
                address_r    <= {addr[31:2], 2'b00};
                write_r      <= 1'b1;
                byteenable_r <= store_lanes(opcode, addr[1:0]);
                writedata_r  <= store_swapped;
            end
            if (state == RD_WAIT && !bus.waitrequest) begin
                read_r      <= 1'b0;
                readdata_eb <= load_swapped;
                lsb_bits    <= pend_lsb;
                opcode_q    <= pend_opcode;
            end
            if (state == WR_WAIT && !bus.waitrequest) begin
                write_r <= 1'b0;
            end
        end
    end

    assign bus.address    = address_r;
    assign bus.read       = read_r;
    assign bus.write      = write_r;
    assign bus.byteenable = byteenable_r;
    assign bus.writedata  = writedata_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: drives CPU requests and the Avalon slave
// response by hand and checks every output against hand-computed values.
module tb_load_store_unit;
    import load_store_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_read = 1'b0;
    logic        req_write = 1'b0;
    logic [5:0]  opcode = '0;
    logic [31:0] addr = '0;
    logic [31:0] store_data = '0;
    logic        stall;
    logic        addr_err;
    logic [31:0] readdata_eb;
    logic [1:0]  lsb_bits;
    logic [5:0]  opcode_q;

    int compared = 0;
    int mismatched = 0;
    int stall_cycles = 0;

    load_store_unit_if bus_if ();

    load_store_unit dut (
        .clk         (clk),
        .reset       (reset),
        .req_read    (req_read),
        .req_write   (req_write),
        .opcode      (opcode),
        .addr        (addr),
        .store_data  (store_data),
        .stall       (stall),
        .addr_err    (addr_err),
        .readdata_eb (readdata_eb),
        .lsb_bits    (lsb_bits),
        .opcode_q    (opcode_q),
        .bus         (bus_if)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Drives the CPU side and the slave response together, then lets logic settle.
    task automatic applyStimulus(input logic rr, input logic rw, input logic [5:0] op,
                                 input logic [31:0] a, input logic [31:0] sd,
                                 input logic wr, input logic [31:0] rd);
        req_read           = rr;
        req_write          = rw;
        opcode             = op;
        addr               = a;
        store_data         = sd;
        bus_if.waitrequest = wr;
        bus_if.readdata    = rd;
        #1;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #2;
    endtask

    initial begin
        bus_if.waitrequest = 1'b1;
        bus_if.readdata    = '0;
        #3;
        checkOutput("rst_stall", 32'(stall), 32'd0);
        checkOutput("rst_addr_err", 32'(addr_err), 32'd0);
        checkOutput("rst_read", 32'(bus_if.read), 32'd0);
        checkOutput("rst_write", 32'(bus_if.write), 32'd0);
        checkOutput("rst_address", bus_if.address, 32'h0);
        checkOutput("rst_byteenable", 32'(bus_if.byteenable), 32'h0);
        checkOutput("rst_writedata", bus_if.writedata, 32'h0);
        checkOutput("rst_readdata_eb", readdata_eb, 32'h0);
        checkOutput("rst_lsb_bits", 32'(lsb_bits), 32'h0);
        checkOutput("rst_opcode_q", 32'(opcode_q), 32'h0);
        @(negedge clk);
        reset = 1'b0;

        $display("[TB] LW 0x100 with one-cycle response");
        nextCycle();
        applyStimulus(1'b1, 1'b0, OPCODE_LW, 32'h100, 32'h0, 1'b0, 32'h11223344);
        stall_cycles = 0;
        stall_cycles += int'(stall);
        checkOutput("lw_idle_stall", 32'(stall), 32'd1);
        checkOutput("lw_idle_read", 32'(bus_if.read), 32'd0);
        nextCycle();
        stall_cycles += int'(stall);
        checkOutput("lw_read", 32'(bus_if.read), 32'd1);
        checkOutput("lw_address", bus_if.address, 32'h100);
        checkOutput("lw_byteenable", 32'(bus_if.byteenable), 32'hF);
        nextCycle();
        stall_cycles += int'(stall);
        checkOutput("lw_done_stall", 32'(stall), 32'd0);
        checkOutput("lw_done_read", 32'(bus_if.read), 32'd0);
        checkOutput("lw_readdata_eb", readdata_eb, 32'h44332211);
        checkOutput("lw_opcode_q", 32'(opcode_q), 32'(OPCODE_LW));
        checkOutput("lw_lsb_bits", 32'(lsb_bits), 32'd0);
        checkOutput("lw_stall_cycles", 32'(stall_cycles), 32'd2);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 6'h0, 32'h0, 32'h0, 1'b0, 32'h0);
        checkOutput("done_ignores_req_read", 32'(bus_if.read), 32'd0);
        checkOutput("done_ignores_req_stall", 32'(stall), 32'd0);

        $display("[TB] SB 0x203 with waitrequest high for three cycles");
        nextCycle();
        applyStimulus(1'b0, 1'b1, OPCODE_SB, 32'h203, 32'hAB, 1'b1, 32'h0);
        stall_cycles = 0;
        stall_cycles += int'(stall);
        checkOutput("sb_idle_stall", 32'(stall), 32'd1);
        for (int i = 0; i < 3; i++) begin
            nextCycle();
            stall_cycles += int'(stall);
            checkOutput("sb_wait_write", 32'(bus_if.write), 32'd1);
            checkOutput("sb_wait_address", bus_if.address, 32'h200);
            checkOutput("sb_wait_byteenable", 32'(bus_if.byteenable), 32'h1);
            checkOutput("sb_wait_writedata", bus_if.writedata, 32'hABABABAB);
        end
        nextCycle();
        applyStimulus(1'b0, 1'b1, OPCODE_SB, 32'h203, 32'hAB, 1'b0, 32'h0);
        stall_cycles += int'(stall);
        checkOutput("sb_last_write", 32'(bus_if.write), 32'd1);
        checkOutput("sb_last_byteenable", 32'(bus_if.byteenable), 32'h1);
        nextCycle();
        stall_cycles += int'(stall);
        checkOutput("sb_done_write", 32'(bus_if.write), 32'd0);
        checkOutput("sb_stall_cycles", 32'(stall_cycles), 32'd5);

        $display("[TB] SH 0x302 data 0xBEEF");
        nextCycle();
        applyStimulus(1'b0, 1'b1, OPCODE_SH, 32'h302, 32'hBEEF, 1'b0, 32'h0);
        checkOutput("sh_idle_stall", 32'(stall), 32'd1);
        nextCycle();
        checkOutput("sh_write", 32'(bus_if.write), 32'd1);
        checkOutput("sh_address", bus_if.address, 32'h300);
        checkOutput("sh_byteenable", 32'(bus_if.byteenable), 32'h3);
        checkOutput("sh_writedata", bus_if.writedata, 32'hEFBEEFBE);
        nextCycle();
        checkOutput("sh_done_stall", 32'(stall), 32'd0);
        checkOutput("sh_done_write", 32'(bus_if.write), 32'd0);
        checkOutput("sh_keeps_readdata_eb", readdata_eb, 32'h44332211);

        $display("[TB] SW 0x500 data 0x11223344");
        nextCycle();
        applyStimulus(1'b0, 1'b1, OPCODE_SW, 32'h500, 32'h11223344, 1'b0, 32'h0);
        nextCycle();
        checkOutput("sw_byteenable", 32'(bus_if.byteenable), 32'hF);
        checkOutput("sw_writedata", bus_if.writedata, 32'h44332211);
        nextCycle();

        $display("[TB] misaligned LH 0x101");
        nextCycle();
        applyStimulus(1'b1, 1'b0, OPCODE_LH, 32'h101, 32'h0, 1'b0, 32'hDEADBEEF);
        checkOutput("lh_mis_addr_err", 32'(addr_err), 32'd1);
        checkOutput("lh_mis_stall", 32'(stall), 32'd0);
        checkOutput("lh_mis_read", 32'(bus_if.read), 32'd0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 6'h0, 32'h0, 32'h0, 1'b0, 32'h0);
        checkOutput("lh_mis_addr_err_clear", 32'(addr_err), 32'd0);
        checkOutput("lh_mis_read_after", 32'(bus_if.read), 32'd0);
        checkOutput("lh_mis_readdata_eb", readdata_eb, 32'h44332211);
        checkOutput("lh_mis_opcode_q", 32'(opcode_q), 32'(OPCODE_LW));

        $display("[TB] read and write together at 0x600");
        nextCycle();
        applyStimulus(1'b1, 1'b1, OPCODE_LW, 32'h600, 32'hFFFFFFFF, 1'b0, 32'h0A0B0C0D);
        nextCycle();
        checkOutput("both_read", 32'(bus_if.read), 32'd1);
        checkOutput("both_write", 32'(bus_if.write), 32'd0);
        checkOutput("both_address", bus_if.address, 32'h600);
        nextCycle();
        checkOutput("both_readdata_eb", readdata_eb, 32'h0D0C0B0A);

        $display("[TB] reset during RD_WAIT");
        nextCycle();
        applyStimulus(1'b1, 1'b0, OPCODE_LW, 32'h400, 32'h0, 1'b1, 32'hCAFEF00D);
        nextCycle();
        checkOutput("rstmid_read_before", 32'(bus_if.read), 32'd1);
        nextCycle();
        checkOutput("rstmid_still_waiting", 32'(stall), 32'd1);
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 6'h0, 32'h0, 32'h0, 1'b1, 32'h0);
        checkOutput("rstmid_read", 32'(bus_if.read), 32'd0);
        checkOutput("rstmid_stall", 32'(stall), 32'd0);
        checkOutput("rstmid_address", bus_if.address, 32'h0);
        checkOutput("rstmid_readdata_eb", readdata_eb, 32'h0);
        #2;
        reset = 1'b0;
        nextCycle();
        applyStimulus(1'b1, 1'b0, OPCODE_LW, 32'h104, 32'h0, 1'b0, 32'hA1B2C3D4);
        checkOutput("rstmid_new_stall", 32'(stall), 32'd1);
        nextCycle();
        checkOutput("rstmid_new_read", 32'(bus_if.read), 32'd1);
        checkOutput("rstmid_new_address", bus_if.address, 32'h104);
        nextCycle();
        checkOutput("rstmid_new_readdata_eb", readdata_eb, 32'hD4C3B2A1);
        checkOutput("rstmid_new_done_read", 32'(bus_if.read), 32'd0);

        $display("[TB] back-to-back LB 0x2 then LBU 0x3");
        nextCycle();
        applyStimulus(1'b1, 1'b0, OPCODE_LB, 32'h2, 32'h0, 1'b0, 32'h55667788);
        nextCycle();
        checkOutput("lb_address", bus_if.address, 32'h0);
        nextCycle();
        checkOutput("lb_lsb_bits", 32'(lsb_bits), 32'd2);
        checkOutput("lb_opcode_q", 32'(opcode_q), 32'(OPCODE_LB));
        checkOutput("lb_readdata_eb", readdata_eb, 32'h88776655);
        nextCycle();
        applyStimulus(1'b1, 1'b0, OPCODE_LBU, 32'h3, 32'h0, 1'b0, 32'h01020304);
        checkOutput("lbu_idle_stall", 32'(stall), 32'd1);
        nextCycle();
        nextCycle();
        checkOutput("lbu_lsb_bits", 32'(lsb_bits), 32'd3);
        checkOutput("lbu_opcode_q", 32'(opcode_q), 32'(OPCODE_LBU));
        checkOutput("lbu_readdata_eb", readdata_eb, 32'h04030201);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 6'h0, 32'h0, 32'h0, 1'b0, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
